// File: rtl/fetch_unit.sv
// RV32 instruction-fetch stage: credit-limited request issue, in-order response
// capture into a small {pc, instr} FIFO, flush/redirect with in-flight discard.
module fetch_unit #(
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = '0,
  parameter int unsigned         DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pc_en_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o
);

  localparam logic [31:0]  NOP = 32'h0000_0013;
  localparam int unsigned  CW  = $clog2(DEPTH + 1);
  localparam int unsigned  IW  = CW + 1;
  localparam int unsigned  PW  = $clog2(DEPTH);

  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  logic            req_valid, req_hs, push, pop;
  logic [IW-1:0]   inflight;
  logic            unused_bt;

  assign unused_bt = ^branch_target_i[1:0];

  always_comb begin
    // Outstanding requests plus buffered entries bound the credit, so a push can never overflow.
    inflight  = IW'(outst_q) + IW'(count_q);
    req_valid = !rst_i && pc_en_i && !flush_i && (inflight < IW'(DEPTH));
    req_hs    = req_valid && imem_req_ready_i;
    push      = !rst_i && imem_rsp_valid_i && !flush_i && (drop_q == '0);
    pop       = (count_q != '0) && !stall_i && !flush_i;
  end

  always_comb begin
    req_pc_d = req_pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    outst_d  = outst_q + CW'(req_hs) - CW'(imem_rsp_valid_i);
    if (flush_i) begin
      req_pc_d = {branch_target_i[XLEN-1:2], 2'b00};
      rsp_pc_d = {branch_target_i[XLEN-1:2], 2'b00};
      drop_d   = outst_q - CW'(imem_rsp_valid_i);
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (req_hs) req_pc_d = req_pc_q + XLEN'(4);
      if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rsp_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(imem_rsp_valid_i && (outst_q == '0)));
      assert (!(push && !pop && (count_q == CW'(DEPTH))));
    end
  end

  always_comb begin
    imem_req_valid_o = req_valid;
    imem_req_addr_o  = req_pc_q;
    instr_valid_o    = (count_q != '0);
    instr_o          = instr_valid_o ? instr_mem_q[rd_ptr_q] : NOP;
    pc_o             = instr_valid_o ? pc_mem_q[rd_ptr_q] : '0;
    opcode_o         = instr_o[6:0];
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory with fixed
// latency, in-order pop checker, and hand-computed per-cycle expectations.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        pc_en_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b1;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_en_i(pc_en_i), .stall_i(stall_i),
    .flush_i(flush_i), .branch_target_i(branch_target_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .pc_o(pc_o), .opcode_o(opcode_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        c_rst = 1'b1, c_pc_en = 1'b1, c_stall = 1'b0, c_flush = 1'b0, c_ready = 1'b1;
  logic [31:0] c_bt = '0;
  int unsigned lat = 1;
  int unsigned cyc = 0;
  int unsigned pops = 0;
  int unsigned max_q = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] q_addr [$];
  int unsigned q_due  [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA5A5_0000 ^ {a[31:2], 2'b11};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, settle, record handshake and check pops.
  task automatic tick();
    logic [31:0] d;
    @(negedge clk_i);
    rst_i = c_rst; pc_en_i = c_pc_en; stall_i = c_stall; flush_i = c_flush;
    branch_target_i = c_bt; imem_req_ready_i = c_ready;
    if (c_rst) begin
      q_addr.delete();
      q_due.delete();
    end
    if (!c_rst && q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
    #1;
    if (imem_req_valid_o && imem_req_ready_i) begin
      q_addr.push_back(imem_req_addr_o);
      q_due.push_back(cyc + lat);
    end
    if (q_addr.size() > max_q) max_q = q_addr.size();
    if (instr_valid_o && !stall_i && !flush_i && !rst_i) begin
      d = mem_word(exp_pc);
      chk("pop_pc", pc_o, exp_pc);
      chk("pop_instr", instr_o, d);
      chk("pop_opcode", {25'b0, opcode_o}, {25'b0, d[6:0]});
      exp_pc += 32'd4;
      pops++;
    end
    if (flush_i && !rst_i) exp_pc = {c_bt[31:2], 2'b00};
    cyc++;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int unsigned l);
    c_rst = 1'b1; c_pc_en = 1'b1; c_stall = 1'b0; c_flush = 1'b0; c_ready = 1'b1; c_bt = '0;
    lat = l;
    ticks(2);
    chk("rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_instr_nop", instr_o, 32'h0000_0013);
    chk("rst_pc_zero", pc_o, 32'd0);
    c_rst = 1'b0;
    exp_pc = '0; pops = 0; max_q = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Streaming with one-cycle memory
    do_reset(1);
    tick();                                   // R0
    chk("s_r0_valid", {31'b0, imem_req_valid_o}, 32'd1);
    chk("s_r0_addr", imem_req_addr_o, 32'h0);
    tick();                                   // R1
    chk("s_r1_addr", imem_req_addr_o, 32'h4);
    chk("s_r1_ivalid", {31'b0, instr_valid_o}, 32'd0);
    tick();                                   // R2
    chk("s_r2_ivalid", {31'b0, instr_valid_o}, 32'd1);
    chk("s_r2_pc", pc_o, 32'h0);
    ticks(9);                                 // R3..R11
    chk("s_pops", pops, 32'd7);
    chk("s_exp_pc", exp_pc, 32'h1C);

    // Latency 3: outstanding saturates at 2
    do_reset(3);
    ticks(12);
    chk("l3_max_outst", max_q, 32'd2);
    chk("l3_pops", pops, 32'd4);

    // Stall with a full FIFO
    do_reset(1);
    c_stall = 1'b1;
    ticks(3);                                 // R0..R2 fill
    for (int unsigned i = 0; i < 5; i++) begin
      tick();                                 // R3..R7 held
      chk("st_ivalid", {31'b0, instr_valid_o}, 32'd1);
      chk("st_pc", pc_o, 32'h0);
      chk("st_instr", instr_o, mem_word(32'h0));
      chk("st_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    end
    c_stall = 1'b0;
    ticks(6);                                 // R8..R13
    chk("st_pops", pops, 32'd4);
    chk("st_exp_pc", exp_pc, 32'h10);

    // Flush with two in flight and a response in the flush cycle
    do_reset(2);
    ticks(2);                                 // R0, R1
    c_flush = 1'b1; c_bt = 32'h103;
    tick();                                   // R2
    c_flush = 1'b0;
    tick();                                   // R3
    chk("fl_r3_ivalid", {31'b0, instr_valid_o}, 32'd0);
    chk("fl_r3_valid", {31'b0, imem_req_valid_o}, 32'd1);
    chk("fl_r3_addr", imem_req_addr_o, 32'h100);
    tick();                                   // R4
    chk("fl_r4_ivalid", {31'b0, instr_valid_o}, 32'd0);
    tick();                                   // R5
    chk("fl_r5_ivalid", {31'b0, instr_valid_o}, 32'd0);
    tick();                                   // R6
    chk("fl_r6_ivalid", {31'b0, instr_valid_o}, 32'd1);
    chk("fl_r6_pc", pc_o, 32'h100);
    chk("fl_r6_instr", instr_o, mem_word(32'h100));
    ticks(4);
    chk("fl_pops", pops, 32'd3);

    // Back-to-back flushes: last target wins
    do_reset(2);
    ticks(2);                                 // R0, R1
    c_flush = 1'b1; c_bt = 32'h200;
    tick();                                   // R2
    c_bt = 32'h300;
    tick();                                   // R3
    chk("ff_r3_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    c_flush = 1'b0;
    tick();                                   // R4
    chk("ff_r4_addr", imem_req_addr_o, 32'h300);
    chk("ff_r4_ivalid", {31'b0, instr_valid_o}, 32'd0);
    chk("ff_drop_zero", {30'b0, dut.drop_q}, 32'd0);
    ticks(3);                                 // R5..R7
    chk("ff_r7_pc", pc_o, 32'h300);
    chk("ff_r7_ivalid", {31'b0, instr_valid_o}, 32'd1);
    ticks(3);

    // Reset mid-stream with a full FIFO, then pc_en gating
    do_reset(1);
    c_stall = 1'b1;
    ticks(4);                                 // R0..R3
    chk("rm_full_ivalid", {31'b0, instr_valid_o}, 32'd1);
    c_rst = 1'b1; c_stall = 1'b0;
    tick();                                   // R4
    chk("rm_r4_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    tick();                                   // R5
    chk("rm_r5_ivalid", {31'b0, instr_valid_o}, 32'd0);
    chk("rm_r5_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
    c_rst = 1'b0; c_pc_en = 1'b0; exp_pc = '0; pops = 0;
    tick();                                   // R6
    chk("rm_pcen_block", {31'b0, imem_req_valid_o}, 32'd0);
    c_pc_en = 1'b1;
    tick();                                   // R7
    chk("rm_restart_valid", {31'b0, imem_req_valid_o}, 32'd1);
    chk("rm_restart_addr", imem_req_addr_o, 32'h0);
    ticks(2);                                 // R8, R9
    chk("rm_r9_pc", pc_o, 32'h0);
    chk("rm_r9_ivalid", {31'b0, instr_valid_o}, 32'd1);

    // Wrap-around past 0xFFFF_FFFC
    do_reset(1);
    c_flush = 1'b1; c_bt = 32'hFFFF_FFFA;
    tick();                                   // R0
    c_flush = 1'b0;
    tick();                                   // R1
    chk("wr_r1_addr", imem_req_addr_o, 32'hFFFF_FFF8);
    tick();                                   // R2
    chk("wr_r2_addr", imem_req_addr_o, 32'hFFFF_FFFC);
    ticks(2);                                 // R3, R4
    chk("wr_r4_addr", imem_req_addr_o, 32'h0);
    ticks(2);                                 // R5, R6
    chk("wr_r6_instr", instr_o, mem_word(32'h0));
    chk("wr_pops", pops, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the 5-stage RV32 pipeline. It sits directly upstream of the decode stage and the hazard unit, and drives the next-PC register.
- Issues in-order word requests to instruction memory over a valid/ready request channel with a variable-latency response channel.
- Buffers returned instructions in a small FIFO and presents them to decode.
- Honours pc_en/stall (load-use) and flush/redirect (taken branch) from the hazard unit.
- Discards responses that are in flight when a flush occurs.

Parameters:
XLEN, 32, data/address width.
RESET_PC, 32'h0000_0000, first fetch address after reset.
DEPTH, 2, instruction FIFO entries; also the maximum number of outstanding requests (power of 2, ≥2).

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
pc_en_i  in  1  hazard unit: 0 blocks new request issue
stall_i  in  1  hazard unit: 1 holds FIFO head (decode not accepting)
flush_i  in  1  hazard unit: taken branch, redirect fetch
branch_target_i  in  XLEN  redirect address, sampled when flush_i=1
imem_req_valid_o  out  1  request valid
imem_req_ready_i  in  1  memory accepts request
imem_req_addr_o  out  XLEN  request word address
imem_rsp_valid_i  in  1  response valid (in order, max 1 per cycle, no backpressure)
imem_rsp_data_i  in  32  response instruction
instr_valid_o  out  1  FIFO head valid
instr_o  out  32  FIFO head instruction; 32'h0000_0013 (NOP) when invalid
pc_o  out  XLEN  PC of instr_o; 0 when invalid
opcode_o  out  7  instr_o[6:0]; feeds the hazard unit load-use check

Behaviour:
State:
- req_pc: next fetch address.
- rsp_pc: PC of next accepted response.
- outstanding: 0..DEPTH.
- drop_cnt: 0..DEPTH.
- FIFO of {pc, instr} with count 0..DEPTH.

Reset (rst_i=1, synchronous, wins over all inputs):
- req_pc = rsp_pc = RESET_PC.
- outstanding = 0, drop_cnt = 0, FIFO empty.
- Outputs: imem_req_valid_o=0, instr_valid_o=0, instr_o=NOP, pc_o=0.
- Reset mid-transaction abandons in-flight responses. The environment guarantees no stale responses after reset.

Request issue:
- imem_req_valid_o = !rst_i & pc_en_i & !flush_i & (outstanding + fifo_count < DEPTH).
- imem_req_addr_o = req_pc.
- Valid need not stay stable without ready; memory acts only on the handshake.
- On handshake, req_pc += 4 and outstanding increments.

Response accept:
- outstanding_next = outstanding + req_hs − imem_rsp_valid_i.
- If drop_cnt > 0: the response is discarded and drop_cnt decrements.
- Otherwise: {rsp_pc, data} is pushed and rsp_pc += 4.
- The credit rule guarantees a push never meets a full FIFO. Overflow, or a response with outstanding=0, is an assertion failure.

Output / pop:
- Output is the FIFO head; response-to-instr_valid_o latency is 1 cycle, with no bypass.
- Pop when instr_valid_o & !stall_i.
- Push and pop in the same cycle is legal, including at full.

Flush (priority over stall and pc_en):
- Takes effect the next cycle; instr_valid_o=0 in the cycle after flush_i.
- FIFO is cleared; no request is issued in the flush cycle.
- req_pc = rsp_pc = {branch_target_i[XLEN-1:2], 2'b00}.
- drop_cnt = outstanding − imem_rsp_valid_i. A response arriving in the flush cycle is itself discarded.
- Flush while drop_cnt>0 recomputes drop_cnt with the same formula.
- Back-to-back flushes: the last target wins.

Wrap-around:
- req_pc and rsp_pc wrap modulo 2^XLEN; 0xFFFF_FFFC + 4 = 0.

Stall:
- stall_i with pc_en_i=1 still fills the FIFO up to its credit.
- pc_en_i=0 only blocks issue; responses still land.

Test Plan:
- Reset, zero-latency memory, always ready, no hazards → requests 0x0,0x4,0x8…; instr_valid_o first high 2 cycles after reset deassert; pc_o sequence 0x0,0x4,0x8 with matching data.
- Memory latency 3, ready always → outstanding saturates at 2; no more than 2 requests without responses; no FIFO overflow; PCs in order.
- stall_i=1 for 5 cycles with FIFO full → instr_o/pc_o held constant; imem_req_valid_o=0; on release, one pop per cycle with no lost or duplicated PC.
- Flush to 0x100 with 2 requests outstanding (latency 2), and a response arriving in the flush cycle → all 2 old responses dropped; next instr_valid_o has pc_o=0x100; branch_target 0x103 yields fetch at 0x100.
- Two flushes on consecutive cycles (0x200 then 0x300) with responses in flight → only 0x300 stream appears; drop_cnt returns to 0.
- rst_i asserted mid-stream with FIFO non-empty → next cycle instr_valid_o=0, imem_req_valid_o=0; after release fetch restarts at RESET_PC.
